regfile_wb_queue: RTL and testbench

Write-back queue that sits on the writer side of the register file. It accepts register write-backs from two producers, the ALU and the load unit, and buffers them in a small in-order FIFO. It drains one write per cycle onto the register file write port (`RD`, `WR`, `WE_reg`). It also gives the decode stage a bypass lookup, so reads of still-pending destinations return the correct value.

---
 rtl/regfile_wb_queue_if.sv | 31 +++
 rtl/regfile_wb_queue.sv | 124 ++++++++++++
 tb/tb_regfile_wb_queue.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_queue_if.sv
// Bundle of producer requests, register-file write port, status and bypass lookup
// signals for the write-back queue.
interface regfile_wb_queue_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        stall;
  logic        overflow;
  logic        WE_reg;
  logic [4:0]  RD;
  logic [31:0] WR;
  logic [4:0]  RS1;
  logic [4:0]  RS2;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, RS1, RS2,
    input  stall, overflow, WE_reg, RD, WR, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, RS1, RS2,
    output stall, overflow, WE_reg, RD, WR, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order write-back FIFO merging ALU and load results, draining one register
// write per cycle, with a combinational bypass lookup over pending writes.
module regfile_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  regfile_wb_queue_if.slave  io_bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);

  logic [4:0]    r_q_rd   [DEPTH];
  logic [31:0]   r_q_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_we;
  logic [4:0]    r_rd;
  logic [31:0]   r_wr;
  logic          r_stall;
  logic          r_ovf;

  logic          w_pop;
  logic          w_ld_req;
  logic          w_alu_req;
  logic          w_ld_acc;
  logic          w_alu_acc;
  logic          w_drop;
  logic [CW-1:0] w_free;
  logic [CW-1:0] w_count_nxt;
  logic [AW-1:0] w_alu_slot;
  logic          w_fwd1_hit;
  logic          w_fwd2_hit;
  logic [31:0]   w_fwd1_data;
  logic [31:0]   w_fwd2_data;

  // Later (newer) matches overwrite earlier ones, so the newest pending write wins;
  // the output register is only the fallback.
  function automatic logic [32:0] f_lookup(input logic [4:0] rs);
    logic          hit;
    logic [31:0]   data;
    logic [AW-1:0] idx;
    logic          match;
    hit  = r_we && (r_rd == rs);
    data = hit ? r_wr : 32'd0;
    for (int k = 0; k < DEPTH; k++) begin
      idx   = r_head + AW'(k);
      match = (CW'(k) < r_count) && (r_q_rd[idx] == rs);
      hit   = hit | match;
      data  = match ? r_q_data[idx] : data;
    end
    return (rs == 5'd0) ? 33'd0 : {hit, data};
  endfunction

  // Admission: the load takes the first free slot, the ALU only gets a second one.
  always_comb begin
    w_pop       = (r_count != {CW{1'b0}});
    w_ld_req    = io_bus.ld_valid && (io_bus.ld_rd != 5'd0);
    w_alu_req   = io_bus.alu_valid && (io_bus.alu_rd != 5'd0);
    w_free      = L_DEPTH - r_count + CW'(w_pop);
    w_ld_acc    = w_ld_req && (w_free != {CW{1'b0}});
    w_alu_acc   = w_alu_req && (w_free > CW'(w_ld_acc));
    w_drop      = (w_ld_req && !w_ld_acc) || (w_alu_req && !w_alu_acc);
    w_count_nxt = r_count - CW'(w_pop) + CW'(w_ld_acc) + CW'(w_alu_acc);
    w_alu_slot  = r_tail + AW'(w_ld_acc);
  end

  // Bypass lookup for both decode read ports.
  always_comb begin
    {w_fwd1_hit, w_fwd1_data} = f_lookup(io_bus.RS1);
    {w_fwd2_hit, w_fwd2_data} = f_lookup(io_bus.RS2);
  end

  // Entry storage; contents need no reset since occupancy gates every use.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_ld_acc) begin
      r_q_rd[r_tail]   <= io_bus.ld_rd;
      r_q_data[r_tail] <= io_bus.ld_data;
    end
    if (!i_rst && w_alu_acc) begin
      r_q_rd[w_alu_slot]   <= io_bus.alu_rd;
      r_q_data[w_alu_slot] <= io_bus.alu_data;
    end
  end

  // Pointers, occupancy, write port and status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= {AW{1'b0}};
      r_tail  <= {AW{1'b0}};
      r_count <= {CW{1'b0}};
      r_we    <= 1'b0;
      r_rd    <= 5'd0;
      r_wr    <= 32'd0;
      r_stall <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_we   <= 1'b1;
        r_rd   <= r_q_rd[r_head];
        r_wr   <= r_q_data[r_head];
        r_head <= r_head + AW'(1);
      end else begin
        r_we   <= 1'b0;
      end
      r_tail  <= r_tail + AW'(w_ld_acc) + AW'(w_alu_acc);
      r_count <= w_count_nxt;
      r_stall <= (w_count_nxt > (L_DEPTH - CW'(2)));
      r_ovf   <= r_ovf | w_drop;
    end
  end

  assign io_bus.WE_reg    = r_we;
  assign io_bus.RD        = r_rd;
  assign io_bus.WR        = r_wr;
  assign io_bus.stall     = r_stall;
  assign io_bus.overflow  = r_ovf;
  assign io_bus.fwd1_hit  = w_fwd1_hit;
  assign io_bus.fwd2_hit  = w_fwd2_hit;
  assign io_bus.fwd1_data = w_fwd1_data;
  assign io_bus.fwd2_data = w_fwd2_data;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue against a queue-based reference model.
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  regfile_wb_queue_if bus();

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));

  always #5 clk = ~clk;

  ent_t        m_q[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_wr = 32'd0;
  logic        m_ovf = 1'b0;
  logic        m_stall = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  // Reference: a write-back queue of at most DEPTH entries, drained one per cycle.
  function automatic logic [32:0] model_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 33'd0;
    for (int i = m_q.size() - 1; i >= 0; i--)
      if (m_q[i].rd == rs) return {1'b1, m_q[i].data};
    if (m_we && m_rd == rs) return {1'b1, m_wr};
    return 33'd0;
  endfunction

  task automatic drive(input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic r);
    int free;
    ent_t e;
    bus.ld_valid = lv;  bus.ld_rd = lrd;  bus.ld_data = ldat;
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = adat;
    rst = r;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_we = 1'b0; m_rd = 5'd0; m_wr = 32'd0; m_ovf = 1'b0; m_stall = 1'b0;
    end else begin
      if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_we = 1'b1; m_rd = e.rd; m_wr = e.data;
      end else begin
        m_we = 1'b0;
      end
      free = DEPTH - m_q.size();
      if (lv && lrd != 5'd0) begin
        if (free > 0) begin m_q.push_back('{lrd, ldat}); free--; end
        else m_ovf = 1'b1;
      end
      if (av && ard != 5'd0) begin
        if (free > 0) begin m_q.push_back('{ard, adat}); free--; end
        else m_ovf = 1'b1;
      end
      m_stall = (m_q.size() > DEPTH - 2);
    end
    @(negedge clk);
    bus.ld_valid = 1'b0; bus.alu_valid = 1'b0; rst = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd8, 32'h2, 1'b1);
    n_checks++;
    if ({bus.WE_reg, bus.RD, bus.WR} !== 38'd0) begin
      n_fail++; $display("FAIL reset_wb: got %b/%0d/%h exp 0/0/0", bus.WE_reg, bus.RD, bus.WR);
    end
    n_checks++;
    if ({bus.stall, bus.overflow} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: got stall=%b ovf=%b exp 0 0", bus.stall, bus.overflow);
    end
    idle();
    n_checks++;
    if (bus.WE_reg !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_write: got WE=%b exp 0", bus.WE_reg);
    end
  endtask

  task automatic test_single_write();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    n_checks++;
    if (bus.WE_reg !== 1'b0) begin
      n_fail++; $display("FAIL single_early: got WE=%b exp 0", bus.WE_reg);
    end
    bus.RS1 = 5'd5; #1;
    n_checks++;
    if ({bus.fwd1_hit, bus.fwd1_data} !== {1'b1, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL single_fwd: got %b/%h exp 1/deadbeef", bus.fwd1_hit, bus.fwd1_data);
    end
    idle();
    n_checks++;
    if ({bus.WE_reg, bus.RD, bus.WR} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL single_write: got %b/%0d/%h exp 1/5/deadbeef", bus.WE_reg, bus.RD, bus.WR);
    end
    idle();
    n_checks++;
    if (bus.WE_reg !== 1'b0) begin
      n_fail++; $display("FAIL single_once: got WE=%b exp 0", bus.WE_reg);
    end
  endtask

  task automatic test_ordering();
    logic [31:0] exp_wr [2];
    exp_wr[0] = 32'h11; exp_wr[1] = 32'h22;
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 1'b0);
    bus.RS1 = 5'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if ({bus.fwd1_hit, bus.fwd1_data} !== {1'b1, 32'h22}) begin
        n_fail++; $display("FAIL order_fwd%0d: got %b/%h exp 1/22", c, bus.fwd1_hit, bus.fwd1_data);
      end
      idle();
      if (c < 2) begin
        n_checks++;
        if ({bus.WE_reg, bus.RD, bus.WR} !== {1'b1, 5'd3, exp_wr[c]}) begin
          n_fail++; $display("FAIL order_wr%0d: got %b/%0d/%h exp 1/3/%h", c, bus.WE_reg, bus.RD, bus.WR, exp_wr[c]);
        end
      end
    end
    #1;
    n_checks++;
    if ({bus.WE_reg, bus.fwd1_hit, bus.fwd1_data} !== 34'd0) begin
      n_fail++; $display("FAIL order_end: got WE=%b hit=%b data=%h exp 0/0/0", bus.WE_reg, bus.fwd1_hit, bus.fwd1_data);
    end
  endtask

  task automatic test_x0_filter();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    bus.RS2 = 5'd0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if ({bus.WE_reg, bus.stall, bus.fwd2_hit, bus.fwd2_data} !== 35'd0) begin
        n_fail++; $display("FAIL x0_filter%0d: got WE=%b stall=%b hit=%b data=%h exp all 0", c, bus.WE_reg, bus.stall, bus.fwd2_hit, bus.fwd2_data);
      end
      idle();
    end
  endtask

  task automatic test_full();
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 5'(2 * c + 1), $urandom, 1'b1, 5'(2 * c + 2), $urandom, 1'b0);
      n_checks++;
      if ({bus.WE_reg, bus.RD, bus.WR, bus.stall, bus.overflow} !== {m_we, m_rd, m_wr, m_stall, m_ovf}) begin
        n_fail++; $display("FAIL full_fill%0d: got %b/%0d/%h s%b o%b exp %b/%0d/%h s%b o%b", c, bus.WE_reg, bus.RD, bus.WR, bus.stall, bus.overflow, m_we, m_rd, m_wr, m_stall, m_ovf);
      end
      if (c == 1 || c == 4) begin
        n_checks++;
        if ({bus.stall, bus.overflow} !== {1'b1, c == 4}) begin
          n_fail++; $display("FAIL full_flags%0d: got s%b o%b exp s1 o%0d", c, bus.stall, bus.overflow, c == 4);
        end
      end
    end
    for (int c = 0; c < 6; c++) begin
      idle();
      n_checks++;
      if ({bus.WE_reg, bus.RD, bus.WR, bus.stall} !== {m_we, m_rd, m_wr, m_stall}) begin
        n_fail++; $display("FAIL full_drain%0d: got %b/%0d/%h s%b exp %b/%0d/%h s%b", c, bus.WE_reg, bus.RD, bus.WR, bus.stall, m_we, m_rd, m_wr, m_stall);
      end
    end
    n_checks++;
    if ({bus.overflow, bus.WE_reg} !== 2'b10) begin
      n_fail++; $display("FAIL full_sticky: got o%b WE%b exp o1 WE0", bus.overflow, bus.WE_reg);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd10, 32'hA, 1'b0);
    drive(1'b1, 5'd11, 32'hB, 1'b1, 5'd12, 32'hC, 1'b0);
    drive(1'b1, 5'd13, 32'hD, 1'b1, 5'd14, 32'hE, 1'b1);
    n_checks++;
    if ({bus.WE_reg, bus.stall, bus.overflow} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_flags: got WE%b s%b o%b exp 000", bus.WE_reg, bus.stall, bus.overflow);
    end
    bus.RS1 = 5'd11;
    for (int c = 0; c < 4; c++) begin
      idle();
      n_checks++;
      if ({bus.WE_reg, bus.fwd1_hit} !== 2'b00) begin
        n_fail++; $display("FAIL midrst_stale%0d: got WE%b hit%b exp 00", c, bus.WE_reg, bus.fwd1_hit);
      end
    end
  endtask

  task automatic test_wrap();
    int next_rd = 1;
    for (int c = 1; c <= 23; c++) begin
      if (c <= 20) drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(c), 32'(c * 32'h100), 1'b0);
      else idle();
      if (bus.WE_reg === 1'b1) begin
        n_checks++;
        if ({bus.RD, bus.WR} !== {5'(next_rd), 32'(next_rd * 32'h100)}) begin
          n_fail++; $display("FAIL wrap_wr: got %0d/%h exp %0d/%h", bus.RD, bus.WR, next_rd, next_rd * 32'h100);
        end
        next_rd++;
      end
    end
    n_checks++;
    if (next_rd !== 21) begin
      n_fail++; $display("FAIL wrap_count: got %0d writes exp 20", next_rd - 1);
    end
  endtask

  task automatic test_random();
    logic [32:0] e1, e2;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    for (int c = 0; c < 400; c++) begin
      bus.RS1 = 5'($urandom_range(0, 7));
      bus.RS2 = 5'($urandom_range(0, 7));
      #1;
      e1 = model_fwd(bus.RS1);
      e2 = model_fwd(bus.RS2);
      n_checks++;
      if ({bus.fwd1_hit, bus.fwd1_data, bus.fwd2_hit, bus.fwd2_data} !== {e1, e2}) begin
        n_fail++; $display("FAIL rand_fwd%0d: got %b/%h %b/%h exp %b/%h %b/%h", c, bus.fwd1_hit, bus.fwd1_data, bus.fwd2_hit, bus.fwd2_data, e1[32], e1[31:0], e2[32], e2[31:0]);
      end
      drive(1'($urandom), 5'($urandom_range(0, 7)), $urandom, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 63) == 0));
      n_checks++;
      if ({bus.WE_reg, bus.RD, bus.WR, bus.stall, bus.overflow} !== {m_we, m_rd, m_wr, m_stall, m_ovf}) begin
        n_fail++; $display("FAIL rand_out%0d: got %b/%0d/%h s%b o%b exp %b/%0d/%h s%b o%b", c, bus.WE_reg, bus.RD, bus.WR, bus.stall, bus.overflow, m_we, m_rd, m_wr, m_stall, m_ovf);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
    bus.ld_valid = 1'b0;  bus.ld_rd = 5'd0;  bus.ld_data = 32'd0;
    bus.RS1 = 5'd0; bus.RS2 = 5'd0;
    @(negedge clk);
    test_reset();
    test_single_write();
    test_ordering();
    test_x0_filter();
    test_full();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
